// File: rtl/pe_pkg.sv
// pe_pkg -- definitions shared by the PE-side feeder logic.
//   DEFAULT_DATA_WIDTH : default pixel width in bits
//   SOR_BIT / EOR_BIT  : tag bit offsets above the pixel field
//                        (a tagged word is {SOR, EOR, pixel})
//   feeder_state_e     : ifmap feeder FSM states
package pe_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  // Offsets relative to DATA_WIDTH: word[DATA_WIDTH+SOR_BIT] = start-of-row,
  // word[DATA_WIDTH+EOR_BIT] = end-of-row.
  localparam int SOR_BIT = 1;
  localparam int EOR_BIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock first-word-fall-through FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write din when push=1 and not full
//   pop        : discard head word when pop=1 and not empty
//   dout       : head word, valid whenever empty=0; forced to 0 when empty
//   full/empty : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage carries no reset; the empty flag masks stale contents on dout.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  assign dout = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ifmap_feeder.sv
// ifmap_feeder -- tags a raw pixel stream with start/end-of-row flags and
// feeds it to the PE ifmap buffer through a small skid FIFO.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : one-cycle pulse, latches row_len/num_rows (IDLE only)
//   row_len, num_rows   : frame geometry
//   pix_in, pix_valid   : source pixel stream; pix_ready = accept this cycle
//   ready_ifm           : PE can take a word
//   w_en_ifm            : write strobe to the PE, data_in_ifm = {SOR,EOR,pixel}
//   busy                : frame in progress (RUN or DRAIN)
//   done                : one-cycle pulse when the frame has fully drained
module ifmap_feeder
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_W-1:0]      row_len,
  input  logic [LEN_W-1:0]      num_rows,
  input  logic [DATA_WIDTH-1:0] pix_in,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic                  ready_ifm,
  output logic                  w_en_ifm,
  output logic [DATA_WIDTH+1:0] data_in_ifm,
  output logic                  busy,
  output logic                  done
);

  localparam int              WORD_W  = DATA_WIDTH + 2;
  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  feeder_state_e     state_q;
  logic [LEN_W-1:0]  col_q;
  logic [LEN_W-1:0]  row_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  rows_q;
  logic              busy_q;
  logic              done_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_dout;
  logic [WORD_W-1:0] push_word;
  logic              accept;
  logic              sor;
  logic              eor;
  logic              last_row;

  assign pix_ready = (state_q == ST_RUN) && !fifo_full;
  assign accept    = pix_valid && pix_ready;

  // With len_q==1 column 0 is also the last column, so both tags assert.
  assign sor      = (col_q == '0);
  assign eor      = (col_q == len_q - LEN_ONE);
  assign last_row = (row_q == rows_q - LEN_ONE);

  always_comb begin
    push_word                      = '0;
    push_word[DATA_WIDTH-1:0]      = pix_in;
    push_word[DATA_WIDTH+SOR_BIT]  = sor;
    push_word[DATA_WIDTH+EOR_BIT]  = eor;
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (w_en_ifm),
    .din   (push_word),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign w_en_ifm    = !fifo_empty && ready_ifm;
  assign data_in_ifm = fifo_dout;
  assign busy        = busy_q;
  assign done        = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      len_q   <= '0;
      rows_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if ((row_len != '0) && (num_rows != '0)) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
              len_q   <= row_len;
              rows_q  <= num_rows;
              col_q   <= '0;
              row_q   <= '0;
            end else begin
              // Empty frame: report completion without writing anything.
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (eor) begin
              col_q <= '0;
              row_q <= row_q + LEN_ONE;
              if (last_row) begin
                state_q <= ST_DRAIN;
              end
            end else begin
              col_q <= col_q + LEN_ONE;
            end
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifmap_feeder.sv
// Scoreboard bench for ifmap_feeder: the pixel driver pushes the expected
// tagged word whenever a pixel is accepted; an independent monitor pops and
// compares on every w_en_ifm strobe.
module tb_ifmap_feeder;

  typedef logic [17:0] word_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  row_len;
  logic [7:0]  num_rows;
  logic [15:0] pix_in;
  logic        pix_valid;
  logic        pix_ready;
  logic        ready_ifm;
  logic        w_en_ifm;
  logic [17:0] data_in_ifm;
  logic        busy;
  logic        done;

  word_t exp_q[$];
  int    checks   = 0;
  int    errors   = 0;
  int    writes   = 0;
  int    done_cnt = 0;
  int    accepts  = 0;
  int    cyc      = 0;
  int    last_wr_cyc = 0;
  int    done_cyc    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  ifmap_feeder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .row_len     (row_len),
    .num_rows    (num_rows),
    .pix_in      (pix_in),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .ready_ifm   (ready_ifm),
    .w_en_ifm    (w_en_ifm),
    .data_in_ifm (data_in_ifm),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Monitor: samples mid low phase, after the driver has settled its inputs.
  always @(negedge clk) begin
    word_t e;
    #2;
    if (w_en_ifm === 1'b1) begin
      writes++;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got 0x%0h expected no write", data_in_ifm);
      end else begin
        e = exp_q.pop_front();
        check("word", data_in_ifm, e);
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Call at a falling edge; returns at a falling edge after acceptance.
  task automatic send_pix(input logic [15:0] v, input logic sor, input logic eor);
    bit ok;
    ok = 1'b0;
    pix_in    = v;
    pix_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (pix_ready === 1'b1) begin
        exp_q.push_back({sor, eor, v});
        accepts++;
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: pixel 0x%0h got pix_ready=0 expected acceptance", v);
    end
  endtask

  task automatic send_frame(input int len, input int rows, input logic [15:0] base);
    for (int k = 0; k < len * rows; k++) begin
      send_pix(base + 16'(k), (k % len) == 0, (k % len) == len - 1);
    end
    pix_valid = 1'b0;
  endtask

  task automatic start_frame(input logic [7:0] len, input logic [7:0] rows);
    start    = 1'b1;
    row_len  = len;
    num_rows = rows;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      #3;
      if (done_cnt != d0) break;
    end
    check({name, "_done_seen"}, done_cnt - d0, 1);
    repeat (3) @(negedge clk);
    check({name, "_done_once"}, done_cnt - d0, 1);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_pix_ready"}, pix_ready, 0);
    check({name, "_w_en"},      w_en_ifm, 0);
    check({name, "_busy"},      busy, 0);
    check({name, "_done"},      done, 0);
    check({name, "_data"},      data_in_ifm, 0);
  endtask

  logic [1:0] t1_tags [6];
  int w0;
  int a0;

  initial begin
    t1_tags = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01};
    rst_n = 1'b0; start = 1'b0; row_len = '0; num_rows = '0;
    pix_in = '0; pix_valid = 1'b0; ready_ifm = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 3x2 frame, explicit tag table, PE always ready
    w0 = writes;
    start_frame(8'd3, 8'd2);
    check("t1_busy", busy, 1);
    for (int k = 0; k < 6; k++) begin
      send_pix(16'(k + 1), t1_tags[k][1], t1_tags[k][0]);
    end
    pix_valid = 1'b0;
    wait_done("t1", 20);
    check("t1_writes", writes - w0, 6);
    check("t1_done_latency_ok", ((done_cyc - last_wr_cyc) >= 1) && ((done_cyc - last_wr_cyc) <= 2), 1);
    check("t1_busy_after", busy, 0);

    // single-pixel rows: every word tagged 11
    w0 = writes;
    start_frame(8'd1, 8'd4);
    send_frame(1, 4, 16'h0100);
    wait_done("t2", 20);
    check("t2_writes", writes - w0, 4);

    // PE stalled for 20 cycles with the source always valid
    w0 = writes;
    a0 = accepts;
    start_frame(8'd4, 8'd2);
    ready_ifm = 1'b0;
    fork
      send_frame(4, 2, 16'h0200);
      begin
        repeat (20) @(negedge clk);
        #1;
        check("t3_accepts_while_stalled", accepts - a0, 4);
        check("t3_pix_ready_full", pix_ready, 0);
        check("t3_no_writes_stalled", writes - w0, 0);
        ready_ifm = 1'b1;
      end
    join
    wait_done("t3", 40);
    check("t3_writes", writes - w0, 8);
    check("t3_queue_empty", exp_q.size(), 0);

    // zero-length frame, then start ignored while running
    w0 = writes;
    start_frame(8'd0, 8'd3);
    wait_done("t4_empty", 2);
    check("t4_empty_writes", writes - w0, 0);
    w0 = writes;
    start_frame(8'd2, 8'd2);
    send_pix(16'h0300, 1'b1, 1'b0);
    send_pix(16'h0301, 1'b0, 1'b1);
    start = 1'b1; row_len = 8'd1; num_rows = 8'd1;
    send_pix(16'h0302, 1'b1, 1'b0);
    start = 1'b0;
    send_pix(16'h0303, 1'b0, 1'b1);
    pix_valid = 1'b0;
    wait_done("t4_run", 20);
    check("t4_run_writes", writes - w0, 4);

    // reset mid-frame with buffered words, then a fresh 2x1 frame
    start_frame(8'd4, 8'd2);
    ready_ifm = 1'b0;
    send_pix(16'h0AA1, 1'b1, 1'b0);
    send_pix(16'h0AA2, 1'b0, 1'b0);
    send_pix(16'h0AA3, 1'b0, 1'b0);
    check("t5_busy_before_reset", busy, 1);
    ready_ifm = 1'b1;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t5_reset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    w0 = writes;
    start_frame(8'd2, 8'd1);
    send_pix(16'h0400, 1'b1, 1'b0);
    send_pix(16'h0401, 1'b0, 1'b1);
    pix_valid = 1'b0;
    wait_done("t5", 20);
    check("t5_writes", writes - w0, 2);
    check("t5_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
